// File: rtl/sync_fifo_if.sv
// sync_fifo_if: the FIFO's write/read handshake and status bundle.
// The master modport is the user of the FIFO. The slave modport is the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_enb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_almost_full;
    logic                  fifo_almost_empty;
    logic                  fifo_overrun;
    logic                  fifo_underrun;

    modport master (
        output wr_enb, wr_data, rd_enb,
        input  rd_data, fifo_full, fifo_empty, fifo_almost_full,
               fifo_almost_empty, fifo_overrun, fifo_underrun
    );

    modport slave (
        input  wr_enb, wr_data, rd_enb,
        output rd_data, fifo_full, fifo_empty, fifo_almost_full,
               fifo_almost_empty, fifo_overrun, fifo_underrun
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered status flags.
// The error pulses fifo_overrun and fifo_underrun are only generated when the macro
// SYNC_FIFO_ERR_FLAGS_EN is defined. Without it, both outputs are tied to 0.
// Rejection of writes and reads works the same way in both builds.
// rst_n is synchronous and active-high. The name is inherited from the surrounding codebase.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_fifo_if.slave    bus
);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE      = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH_M1 = CNT_DEPTH - CNT_ONE;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Accept/reject decision and post-edge occupancy.
    // A full FIFO still takes a write when a read frees a slot at the same edge.
    always_comb begin
        w_rd_acc    = bus.rd_enb && !r_empty;
        w_wr_acc    = bus.wr_enb && (!r_full || w_rd_acc);
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    // Pointers and occupancy count. Both pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_nxt;
        end
    end

    // Storage array. It is not cleared on reset; clearing the pointers is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (!rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Registered read data. It holds its value unless a read is accepted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Status flags are decoded from the next count, so they change at the same edge as the count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_full   <= (w_count_nxt == CNT_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= CNT_DEPTH_M1);
            r_aempty <= (w_count_nxt <= CNT_ONE);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overrun;
    logic r_underrun;

    // One-cycle pulses that mark a write or read rejected at the previous edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= bus.wr_enb && !w_wr_acc;
            r_underrun <= bus.rd_enb && !w_rd_acc;
        end
    end

    assign bus.fifo_overrun  = r_overrun;
    assign bus.fifo_underrun = r_underrun;
`else
    assign bus.fifo_overrun  = 1'b0;
    assign bus.fifo_underrun = 1'b0;
`endif

    assign bus.rd_data           = r_rd_data;
    assign bus.fifo_full         = r_full;
    assign bus.fifo_empty        = r_empty;
    assign bus.fifo_almost_full  = r_afull;
    assign bus.fifo_almost_empty = r_aempty;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table followed by a randomized run against a queue-based model.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit          rst;
        bit          wr;
        bit          rd;
        logic [7:0]  d;
        logic [7:0]  e_rd;
        int          e_cnt;
        bit          e_ovr;
        bit          e_udr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    vec_t vecs[$];

    logic [7:0] m_q[$];
    logic [7:0] m_rd;
    bit         m_ovr;
    bit         m_udr;

    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(bit rst, bit wr, bit rd, logic [7:0] d,
                       logic [7:0] e_rd, int e_cnt, bit e_ovr, bit e_udr);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.d = d;
        v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_ovr = e_ovr; v.e_udr = e_udr;
        vecs.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(string tag, logic [7:0] e_rd, int e_cnt, bit e_ovr, bit e_udr);
        chk({tag, " rd_data"},      32'(bus.rd_data),           32'(e_rd));
        chk({tag, " full"},         32'(bus.fifo_full),         32'(e_cnt == DEPTH));
        chk({tag, " empty"},        32'(bus.fifo_empty),        32'(e_cnt == 0));
        chk({tag, " almost_full"},  32'(bus.fifo_almost_full),  32'(e_cnt >= DEPTH - 1));
        chk({tag, " almost_empty"}, 32'(bus.fifo_almost_empty), 32'(e_cnt <= 1));
        chk({tag, " overrun"},      32'(bus.fifo_overrun),      32'(e_ovr & ERR_EN));
        chk({tag, " underrun"},     32'(bus.fifo_underrun),     32'(e_udr & ERR_EN));
    endtask

    task automatic apply(bit rst, bit wr, bit rd, logic [7:0] d);
        rst_n       = rst;
        bus.wr_enb  = wr;
        bus.rd_enb  = rd;
        bus.wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(bit rst, bit wr, bit rd, logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            m_q.delete();
            m_rd  = 8'h00;
            m_ovr = 1'b0;
            m_udr = 1'b0;
        end else begin
            rd_ok = rd && (m_q.size() > 0);
            wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
            m_ovr = wr && !wr_ok;
            m_udr = rd && !rd_ok;
            if (rd_ok) m_rd = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
        end
    endtask

    initial begin
        int wr_pct;
        int rd_pct;
        bit r_rst;
        bit r_wr;
        bit r_rd;
        logic [7:0] r_d;

        n_checks    = 0;
        n_err       = 0;
        rst_n       = 1'b1;
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
        bus.wr_data = '0;

        // Reset, then a single entry written and read back.
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'hAA, 8'h00, 1, 0, 0);
        add(0, 0, 1, 8'h00, 8'hAA, 0, 0, 0);
        // Fill with 10..17, one overrun attempt, then an idle cycle.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h10 + i), 8'hAA, i + 1, 0, 0);
        add(0, 1, 0, 8'h99, 8'hAA, 8, 1, 0);
        add(0, 0, 0, 8'h00, 8'hAA, 8, 0, 0);
        // Drain, then one underrun attempt (rd_data stays at 17), then an idle cycle.
        for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 8'(8'h10 + i), 7 - i, 0, 0);
        add(0, 0, 1, 8'h00, 8'h17, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'h17, 0, 0, 0);
        // Refill; write and read together while full; drain so that 55 comes out last.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h10 + i), 8'h17, i + 1, 0, 0);
        add(0, 1, 1, 8'h55, 8'h10, 8, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 8'h00, 8'(8'h11 + i), 7 - i, 0, 0);
        add(0, 0, 1, 8'h00, 8'h55, 0, 0, 0);
        // Write and read together while empty: only the write is performed.
        add(0, 1, 1, 8'h66, 8'h55, 1, 0, 1);
        add(0, 0, 1, 8'h00, 8'h66, 0, 0, 0);
        // Reset in mid-operation wins over enables that are active at the same edge.
        add(0, 1, 0, 8'h01, 8'h66, 1, 0, 0);
        add(0, 1, 0, 8'h02, 8'h66, 2, 0, 0);
        add(0, 1, 0, 8'h03, 8'h66, 3, 0, 0);
        add(1, 1, 1, 8'h04, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 0, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].d);
            check_state($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_cnt,
                        vecs[i].e_ovr, vecs[i].e_udr);
        end

        // Randomized traffic with a shifting write/read bias and occasional resets.
        apply(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 8'h00);
        wr_pct = 50;
        rd_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                wr_pct = $urandom_range(10, 90);
                rd_pct = $urandom_range(10, 90);
            end
            r_rst = ($urandom_range(0, 299) == 0);
            r_wr  = ($urandom_range(0, 99) < wr_pct);
            r_rd  = ($urandom_range(0, 99) < rd_pct);
            r_d   = 8'($urandom);
            apply(r_rst, r_wr, r_rd, r_d);
            model_step(r_rst, r_wr, r_rd, r_d);
            check_state($sformatf("rnd%0d", c), m_rd, m_q.size(), m_ovr, m_udr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of storage entries (power of two).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the pointer width, equal to log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (1 = reset); the port name is kept as the codebase names it.
REQ-006 The block SHALL have port wr_enb, input, 1 bit: write request.
REQ-007 The block SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-008 The block SHALL have port rd_enb, input, 1 bit: read request.
REQ-009 The block SHALL have port rd_data, output, DATA_WIDTH bits: registered read data.
REQ-010 The block SHALL have port fifo_full, output, 1 bit: count == DEPTH.
REQ-011 The block SHALL have port fifo_empty, output, 1 bit: count == 0.
REQ-012 The block SHALL have port fifo_almost_full, output, 1 bit: count >= DEPTH-1.
REQ-013 The block SHALL have port fifo_almost_empty, output, 1 bit: count <= 1.
REQ-014 The block SHALL have port fifo_overrun, output, 1 bit: one-cycle pulse on a rejected write.
REQ-015 The block SHALL have port fifo_underrun, output, 1 bit: one-cycle pulse on a rejected read.

Function
REQ-016 The block SHALL hold an occupancy count of ADDR_WIDTH+1 bits (0..DEPTH) plus write and read pointers of ADDR_WIDTH bits each; both pointers wrap from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when wr_enb=1 and (fifo_full=0 or a read is accepted in the same cycle): mem[wr_ptr] <= wr_data, and wr_ptr increments.
REQ-018 A read SHALL be accepted when rd_enb=1 and fifo_empty=0: rd_data <= mem[rd_ptr] at that same edge (data visible immediately after the edge), and rd_ptr increments.
REQ-019 rd_data SHALL hold its previous value in any cycle without an accepted read.
REQ-020 The count SHALL increment on an accepted write only, decrement on an accepted read only, and remain unchanged when both occur in the same cycle.
REQ-021 When full with wr_enb=1 and rd_enb=1, both the read and the write SHALL be performed, the count SHALL stay DEPTH, and no overrun SHALL be flagged.
REQ-022 When empty with wr_enb=1 and rd_enb=1, only the write SHALL be performed, fifo_underrun SHALL pulse, and rd_data SHALL hold.
REQ-023 All status flags SHALL be registered and SHALL reflect the post-edge count in the same cycle as the count update.
REQ-024 fifo_overrun SHALL be 1 for exactly the cycle after an edge at which a write was rejected, and 0 otherwise.
REQ-025 fifo_underrun SHALL be 1 for exactly the cycle after an edge at which a read was rejected, and 0 otherwise.
REQ-026 A rejected write SHALL alter neither memory, pointers, nor count.

Reset
REQ-027 While rst_n=1 at a rising clk edge, the block SHALL set pointers=0, count=0, rd_data=0, fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0, fifo_overrun=0, fifo_underrun=0.
REQ-028 Reset SHALL take priority over simultaneous wr_enb/rd_enb, and asserting it mid-operation SHALL discard all stored entries; memory contents need not be cleared.

Configuration
REQ-029 With macro SYNC_FIFO_ERR_FLAGS_EN defined, fifo_overrun and fifo_underrun SHALL behave per REQ-024 and REQ-025.
REQ-030 Without SYNC_FIFO_ERR_FLAGS_EN, fifo_overrun and fifo_underrun SHALL be tied to constant 0, while rejection of writes and reads is unchanged.

Verification
REQ-031 Reset: assert rst_n=1 for one edge -> fifo_empty=1, fifo_almost_empty=1, rd_data=00, all other flags 0.
REQ-032 Single entry: write 8'hAA, then read -> rd_data=AA right after the read edge, fifo_empty=1 afterwards.
REQ-033 Fill: write 10..17 on 8 consecutive edges -> fifo_almost_full=1 after the 7th write, fifo_full=1 after the 8th; a 9th write gives fifo_overrun=1 for one cycle and contents unchanged.
REQ-034 Drain: 8 consecutive reads -> rd_data=10,11,...,17 in order, fifo_almost_empty=1 after the 7th read, fifo_empty=1 after the 8th; a 9th read gives fifo_underrun=1 for one cycle and rd_data holds 17.
REQ-035 Simultaneous access: when full, set wr_enb=rd_enb=1 with wr_data=55 -> rd_data=10, fifo_full stays 1, no overrun, and 55 is read out last after wrap-around.
REQ-036 Mid-operation reset: write 3 entries, then assert reset -> fifo_empty=1, count=0, and a subsequent read gives underrun with rd_data=00.
